// File: rtl/gpio_ctrl.sv
// Parametrised GPIO peripheral for the rysy word-addressed slave port: per-pin direction,
// atomic set/clear, synchronised inputs and edge interrupts with write-1-to-clear pending bits.
module gpio_ctrl #(
  parameter int          N_GPIO      = 4,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] RESET_OUT   = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        addr,
  input  logic [3:0]        be,
  input  logic [31:0]       wdata,
  input  logic              we,
  output logic [31:0]       q,
  input  logic [N_GPIO-1:0] gpio_in,
  output logic [N_GPIO-1:0] gpio_out,
  output logic [N_GPIO-1:0] gpio_oe,
  output logic              irq
);

  localparam logic [2:0] A_DATA_OUT = 3'd0;
  localparam logic [2:0] A_DIR      = 3'd1;
  localparam logic [2:0] A_DATA_IN  = 3'd2;
  localparam logic [2:0] A_RISE_EN  = 3'd3;
  localparam logic [2:0] A_FALL_EN  = 3'd4;
  localparam logic [2:0] A_PENDING  = 3'd5;
  localparam logic [2:0] A_SET      = 3'd6;
  localparam logic [2:0] A_CLR      = 3'd7;

  localparam logic [N_GPIO-1:0] DATA_OUT_RST = RESET_OUT[N_GPIO-1:0];

  logic [N_GPIO-1:0] data_out_q, data_out_d;
  logic [N_GPIO-1:0] dir_q, dir_d;
  logic [N_GPIO-1:0] rise_en_q, rise_en_d;
  logic [N_GPIO-1:0] fall_en_q, fall_en_d;
  logic [N_GPIO-1:0] pending_q, pending_d;
  logic [N_GPIO-1:0] prev_q, prev_d;
  logic [N_GPIO-1:0] sync_q [SYNC_STAGES];
  logic [N_GPIO-1:0] sync_d [SYNC_STAGES];
  logic [31:0]       q_q, q_d;
  logic              irq_q, irq_d;

  logic [31:0]       byte_mask_s;
  logic [31:0]       wbits_s;
  logic [N_GPIO-1:0] mask_n_s;
  logic [N_GPIO-1:0] wbits_n_s;
  logic [N_GPIO-1:0] w1c_s;
  logic [N_GPIO-1:0] data_in_s;
  logic [N_GPIO-1:0] event_s;
  logic              unused_s;

  function automatic logic [N_GPIO-1:0] byte_merge(input logic [N_GPIO-1:0] old_v,
                                                   input logic [N_GPIO-1:0] new_v,
                                                   input logic [N_GPIO-1:0] mask_v);
    return (old_v & ~mask_v) | (new_v & mask_v);
  endfunction

  function automatic logic [31:0] zext(input logic [N_GPIO-1:0] v);
    logic [31:0] r;
    r = 32'h0000_0000;
    r[N_GPIO-1:0] = v;
    return r;
  endfunction

  assign byte_mask_s = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  assign wbits_s     = wdata & byte_mask_s;
  assign mask_n_s    = byte_mask_s[N_GPIO-1:0];
  assign wbits_n_s   = wbits_s[N_GPIO-1:0];
  assign data_in_s   = sync_q[SYNC_STAGES-1];
  assign unused_s    = ^{addr[7:3], wbits_s};

  // Input synchroniser shift and edge detection against the previous sample.
  always_comb begin
    sync_d[0] = gpio_in;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    prev_d  = data_in_s;
    event_s = (data_in_s & ~prev_q & rise_en_q) | (~data_in_s & prev_q & fall_en_q);
  end

  // Register writes; an event in the same cycle as its W1C keeps the bit set.
  always_comb begin
    data_out_d = data_out_q;
    dir_d      = dir_q;
    rise_en_d  = rise_en_q;
    fall_en_d  = fall_en_q;
    w1c_s      = '0;
    if (we) begin
      case (addr[2:0])
        A_DATA_OUT: data_out_d = byte_merge(data_out_q, wbits_n_s, mask_n_s);
        A_DIR:      dir_d      = byte_merge(dir_q, wbits_n_s, mask_n_s);
        A_RISE_EN:  rise_en_d  = byte_merge(rise_en_q, wbits_n_s, mask_n_s);
        A_FALL_EN:  fall_en_d  = byte_merge(fall_en_q, wbits_n_s, mask_n_s);
        A_PENDING:  w1c_s      = wbits_n_s;
        A_SET:      data_out_d = data_out_q | wbits_n_s;
        A_CLR:      data_out_d = data_out_q & ~wbits_n_s;
        default:    w1c_s      = '0;
      endcase
    end else begin
      w1c_s = '0;
    end
    pending_d = (pending_q & ~w1c_s) | event_s;
    irq_d     = |pending_d;
  end

  // Read mux samples pre-write register contents.
  always_comb begin
    case (addr[2:0])
      A_DATA_OUT: q_d = zext(data_out_q);
      A_DIR:      q_d = zext(dir_q);
      A_DATA_IN:  q_d = zext(data_in_s);
      A_RISE_EN:  q_d = zext(rise_en_q);
      A_FALL_EN:  q_d = zext(fall_en_q);
      A_PENDING:  q_d = zext(pending_q);
      default:    q_d = 32'h0000_0000;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out_q <= DATA_OUT_RST;
      dir_q      <= '0;
      rise_en_q  <= '0;
      fall_en_q  <= '0;
      pending_q  <= '0;
      prev_q     <= '0;
      q_q        <= 32'h0000_0000;
      irq_q      <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      data_out_q <= data_out_d;
      dir_q      <= dir_d;
      rise_en_q  <= rise_en_d;
      fall_en_q  <= fall_en_d;
      pending_q  <= pending_d;
      prev_q     <= prev_d;
      q_q        <= q_d;
      irq_q      <= irq_d;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
    end
  end

  assign q        = q_q;
  assign gpio_out = data_out_q;
  assign gpio_oe  = dir_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Directed bench for gpio_ctrl: a 16-pin and a 4-pin instance share the bus and pin stimulus.
module tb_gpio_ctrl;

  logic        clk;
  logic        rst;
  logic [7:0]  addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        we;
  logic [15:0] gin;

  logic [31:0] q16, q4;
  logic [15:0] out16, oe16;
  logic [3:0]  out4, oe4;
  logic        irq16, irq4;

  int n_checks;
  int n_errors;

  gpio_ctrl #(.N_GPIO(16), .SYNC_STAGES(2), .RESET_OUT(32'h0000_5A5A)) u_dut16 (
    .clk(clk), .rst(rst), .addr(addr), .be(be), .wdata(wdata), .we(we), .q(q16),
    .gpio_in(gin), .gpio_out(out16), .gpio_oe(oe16), .irq(irq16)
  );

  gpio_ctrl #(.N_GPIO(4), .SYNC_STAGES(2), .RESET_OUT(32'hFFFF_FFF3)) u_dut4 (
    .clk(clk), .rst(rst), .addr(addr), .be(be), .wdata(wdata), .we(we), .q(q4),
    .gpio_in(gin[3:0]), .gpio_out(out4), .gpio_oe(oe4), .irq(irq4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] b);
    addr  = {5'd0, a};
    wdata = d;
    be    = b;
    we    = 1'b1;
    tick();
    we    = 1'b0;
    be    = 4'b0000;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string tag);
    addr = {5'd0, a};
    we   = 1'b0;
    tick();
    check_eq(tag, q16, exp);
  endtask

  logic [31:0] exp_map [8];

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1; addr = 8'd0; be = 4'b0000; wdata = 32'h0; we = 1'b0; gin = 16'h0000;
    #12;
    check_eq("rst_out16", {16'h0, out16}, 32'h0000_5A5A);
    check_eq("rst_out4", {28'h0, out4}, 32'h0000_0003);
    check_eq("rst_oe16", {16'h0, oe16}, 32'h0);
    check_eq("rst_q16", q16, 32'h0);
    check_eq("rst_irq", {31'h0, irq16}, 32'h0);
    tick();
    rst = 1'b0;

    // Byte enables, SET/CLR, read-during-write
    wr(3'd0, 32'h0000_ABCD, 4'b0001);
    check_eq("rdw_q_old", q16, 32'h0000_5A5A);
    check_eq("be_out16", {16'h0, out16}, 32'h0000_5ACD);
    check_eq("be_out4", {28'h0, out4}, 32'h0000_000D);
    wr(3'd6, 32'h0000_0100, 4'b0011);
    check_eq("set_out16", {16'h0, out16}, 32'h0000_5BCD);
    check_eq("set_out4", {28'h0, out4}, 32'h0000_000D);
    wr(3'd6, 32'h0000_FF00, 4'b0001);
    check_eq("set_be_off", {16'h0, out16}, 32'h0000_5BCD);
    wr(3'd7, 32'h0000_0005, 4'b1111);
    check_eq("clr_out16", {16'h0, out16}, 32'h0000_5BC8);
    check_eq("clr_out4", {28'h0, out4}, 32'h0000_0008);
    rd(3'd6, 32'h0, "rd_set");
    rd(3'd7, 32'h0, "rd_clr");
    rd(3'd0, 32'h0000_5BC8, "rd_dout");
    wr(3'd0, 32'h0000_1234, 4'b1111);
    check_eq("rdw2_q_old", q16, 32'h0000_5BC8);
    check_eq("wr_full", {16'h0, out16}, 32'h0000_1234);

    // Input sync latency
    gin = 16'h0001; addr = 8'd2;
    tick();
    check_eq("sync_e0", q16, 32'h0);
    tick();
    check_eq("sync_e1", q16, 32'h0);
    tick();
    check_eq("sync_e2", q16, 32'h1);

    // Rising interrupt, masked fall, W1C
    wr(3'd3, 32'h0000_0001, 4'b1111);
    gin = 16'h0000;
    for (int i = 0; i < 4; i++) tick();
    check_eq("fall_masked_irq", {31'h0, irq16}, 32'h0);
    rd(3'd5, 32'h0, "fall_masked_pend");
    gin = 16'h0001;
    tick();
    tick();
    check_eq("rise_irq_e1", {31'h0, irq16}, 32'h0);
    tick();
    check_eq("rise_irq_e2", {31'h0, irq16}, 32'h1);
    rd(3'd5, 32'h1, "rise_pend");
    wr(3'd5, 32'h0000_0001, 4'b0000);
    check_eq("w1c_be_off", {31'h0, irq16}, 32'h1);
    wr(3'd3, 32'h0000_0000, 4'b1111);
    rd(3'd5, 32'h1, "en_clr_keeps");
    gin = 16'h0000;
    for (int i = 0; i < 4; i++) tick();
    rd(3'd5, 32'h1, "fall_no_change");
    wr(3'd5, 32'h0000_0001, 4'b0001);
    check_eq("w1c_irq", {31'h0, irq16}, 32'h0);
    rd(3'd5, 32'h0, "w1c_pend");

    // W1C race on pin 1
    wr(3'd3, 32'h0000_0003, 4'b1111);
    gin = 16'h0001;
    for (int i = 0; i < 3; i++) tick();
    check_eq("race_pre_irq", {31'h0, irq16}, 32'h1);
    gin = 16'h0003;
    tick();
    tick();
    wr(3'd5, 32'h0000_0002, 4'b0001);
    check_eq("race_irq", {31'h0, irq16}, 32'h1);
    rd(3'd5, 32'h3, "race_pend");
    wr(3'd5, 32'h0000_0003, 4'b0001);
    check_eq("race_clr_irq", {31'h0, irq16}, 32'h0);

    // Reset mid-operation
    wr(3'd4, 32'h0000_0001, 4'b1111);
    wr(3'd1, 32'h0000_FFFF, 4'b0011);
    check_eq("dir_oe16", {16'h0, oe16}, 32'h0000_FFFF);
    gin = 16'h0000;
    for (int i = 0; i < 3; i++) tick();
    check_eq("fall_irq", {31'h0, irq16}, 32'h1);
    rst = 1'b1;
    #1;
    check_eq("arst_irq", {31'h0, irq16}, 32'h0);
    check_eq("arst_out16", {16'h0, out16}, 32'h0000_5A5A);
    check_eq("arst_oe16", {16'h0, oe16}, 32'h0);
    tick();
    tick();
    rst = 1'b0;
    exp_map[0] = 32'h0000_5A5A;
    for (int i = 1; i < 8; i++) exp_map[i] = 32'h0;
    for (int i = 0; i < 8; i++) begin
      rd(3'(i), exp_map[i], $sformatf("rb_addr%0d", i));
    end
    check_eq("rb_out4", {28'h0, out4}, 32'h0000_0003);
    check_eq("rb_irq", {31'h0, irq16}, 32'h0);

    // Width boundary
    wr(3'd1, 32'hFFFF_FFFF, 4'b1111);
    wr(3'd3, 32'hFFFF_FFFF, 4'b1111);
    check_eq("wb_oe4", {28'h0, oe4}, 32'h0000_000F);
    rd(3'd1, 32'h0000_FFFF, "wb_dir16");
    check_eq("wb_dir4", q4, 32'h0000_000F);
    rd(3'd3, 32'h0000_FFFF, "wb_rise16");
    check_eq("wb_rise4", q4, 32'h0000_000F);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
